mma_result_drain: RTL and testbench

Reader at the output end of the N x N systolic MMA array. The array holds 16-bit accumulators in its processing elements. This block snapshots all of them in one cycle when the array reports compute complete. It then streams the results out one element per transfer over a valid/ready interface, and pulses a clear so the array can start the next tile while the drain is still in progress.

---
 rtl/mma_result_drain_if.sv | 16 +
 rtl/mma_result_drain.sv | 90 +++++++++
 tb/tb_mma_result_drain.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/mma_result_drain_if.sv
// Result stream leaving mma_result_drain: one accumulator element per valid/ready transfer.
interface mma_result_drain_if #(
  parameter int N     = 4,
  parameter int ACC_W = 16
);
  localparam int IDX_W = $clog2(N*N);

  logic [ACC_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;
  logic [IDX_W-1:0] out_idx;

  modport master (output out_data, out_valid, out_last, out_idx, input out_ready);
  modport slave  (input out_data, out_valid, out_last, out_idx, output out_ready);
endinterface

// File: rtl/mma_result_drain.sv
// Snapshots the N x N MMA accumulators on capture and streams them out one per transfer.
// Define MMA_DRAIN_TRANSPOSE_EN for column-major emission (row-major otherwise).
module mma_result_drain #(
  parameter  int N     = 4,
  parameter  int ACC_W = 16,
  localparam int IDX_W = $clog2(N*N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N*N*ACC_W-1:0] c_flat,
  input  logic                 capture,
  output logic                 acc_clear,
  mma_result_drain_if.master   out,
  output logic                 busy,
  output logic                 done,
  output logic                 overrun
);
  typedef enum logic {IDLE, DRAIN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N*N-1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] rd_addr;
  logic [ACC_W-1:0] bank [N*N];
  logic             out_valid_q;
  logic             out_last_q;
  logic             xfer;

`ifdef MMA_DRAIN_TRANSPOSE_EN
  // Emission index i maps to (r,c) = (i%N, i/N) in the row-major bank.
  assign rd_addr = IDX_W'((int'(idx) % N) * N + int'(idx) / N);
`else
  assign rd_addr = idx;
`endif

  assign xfer          = out_valid_q && out.out_ready;
  assign out.out_data  = bank[rd_addr];
  assign out.out_valid = out_valid_q;
  assign out.out_last  = out_last_q;
  assign out.out_idx   = idx;
  assign busy          = (state == DRAIN);

  // NOTE: the bank is a register array, not a RAM, so it can (and must) be cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      acc_clear   <= 1'b0;
      done        <= 1'b0;
      overrun     <= 1'b0;
      for (int i = 0; i < N*N; i++) bank[i] <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the pre-edge values.
      acc_clear <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (capture) begin
            for (int i = 0; i < N*N; i++) bank[i] <= c_flat[i*ACC_W +: ACC_W];
            idx         <= '0;
            state       <= DRAIN;
            out_valid_q <= 1'b1;
            out_last_q  <= 1'b0;
            acc_clear   <= 1'b1;
          end
        end
        DRAIN: begin
          // A capture here would overwrite a tile still being read; flag it and drop it.
          if (capture) overrun <= 1'b1;
          if (xfer) begin
            if (idx == LAST_IDX) begin
              state       <= IDLE;
              idx         <= '0;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              done        <= 1'b1;
            end else begin
              idx        <= idx + 1'b1;
              out_last_q <= (idx == LAST_IDX - 1'b1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mma_result_drain.sv
// Self-checking bench for mma_result_drain: directed tiles plus random data/backpressure.
module tb_mma_result_drain;
  localparam int N     = 4;
  localparam int ACC_W = 16;
  localparam int NN    = N*N;

  logic              clk = 1'b0;
  logic              reset;
  logic [NN*ACC_W-1:0] c_flat;
  logic              capture;
  logic              acc_clear, busy, done, overrun;

  mma_result_drain_if #(.N(N), .ACC_W(ACC_W)) out_if ();

  mma_result_drain #(.N(N), .ACC_W(ACC_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .c_flat   (c_flat),
    .capture  (capture),
    .acc_clear(acc_clear),
    .out      (out_if.master),
    .busy     (busy),
    .done     (done),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [ACC_W-1:0] elem [N][N];
  logic [ACC_W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [NN*ACC_W-1:0] pack_elems();
    logic [NN*ACC_W-1:0] v;
    v = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) v[(r*N+c)*ACC_W +: ACC_W] = elem[r][c];
    return v;
  endfunction

  // Expected emission order straight from the (r,c) rule of each mode.
  task automatic build_expected();
    exp_q.delete();
    for (int i = 0; i < NN; i++) begin
`ifdef MMA_DRAIN_TRANSPOSE_EN
      exp_q.push_back(elem[i % N][i / N]);
`else
      exp_q.push_back(elem[i / N][i % N]);
`endif
    end
  endtask

  task automatic fill_pattern();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) elem[r][c] = ACC_W'(16'h0100 * r + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) elem[r][c] = ACC_W'($urandom);
  endtask

  task automatic fill_const(input logic [ACC_W-1:0] v);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) elem[r][c] = v;
  endtask

  // Called at #1 after an edge with the DUT idle; returns in the first DRAIN cycle.
  task automatic start_capture(input string tag);
    c_flat = pack_elems();
    build_expected();
    capture = 1'b1;
    @(posedge clk); #1;
    capture = 1'b0;
    check({tag, "_acc_clear"}, acc_clear, 1);
    check({tag, "_valid0"}, out_if.out_valid, 1);
    check({tag, "_busy0"}, busy, 1);
    check({tag, "_idx0"}, out_if.out_idx, 0);
    check({tag, "_last0"}, out_if.out_last, 0);
    check({tag, "_done0"}, done, 0);
  endtask

  // mode 0: ready always; 1: ready 1,0,0 repeating; 2: random ready.
  // cap_a/cap_b: transfer numbers at which capture is pulsed; ff_at: transfer at which
  // c_flat is overwritten with all ones; stop_at: return before that transfer.
  task automatic drain(input string tag, input int mode, input int cap_a, input int cap_b,
                       input int ff_at, input int stop_at);
    int   k     = 0;
    int   cyc   = 0;
    int   phase = 0;
    logic rdy;
    while (k < NN) begin
      if (k == stop_at) return;
      if (cyc > 20*NN) begin
        checks++;
        failures++;
        $error("FAIL %s_timeout observed=%0d cycles expected<=%0d", tag, cyc, 20*NN);
        break;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (phase % 3 == 0);
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      phase++;
      out_if.out_ready = rdy;
      check($sformatf("%s_valid%0d", tag, k), out_if.out_valid, 1);
      check($sformatf("%s_busy%0d", tag, k), busy, 1);
      check($sformatf("%s_data%0d", tag, k), out_if.out_data, exp_q[k]);
      check($sformatf("%s_idx%0d", tag, k), out_if.out_idx, k);
      check($sformatf("%s_last%0d", tag, k), out_if.out_last, (k == NN-1));
      check($sformatf("%s_clr%0d", tag, k), acc_clear, (cyc == 0));
      capture = rdy && (k == cap_a || k == cap_b);
      if (k == ff_at) c_flat = '1;
      if (rdy) k++;
      cyc++;
      @(posedge clk); #1;
    end
    capture          = 1'b0;
    out_if.out_ready = 1'b0;
    if (mode == 0) check({tag, "_cycles"}, cyc, NN);
    check({tag, "_done"}, done, 1);
    check({tag, "_valid_end"}, out_if.out_valid, 0);
    check({tag, "_busy_end"}, busy, 0);
    check({tag, "_last_end"}, out_if.out_last, 0);
    check({tag, "_clr_end"}, acc_clear, 0);
  endtask

  task automatic idle_cycle(input string tag, input logic exp_overrun);
    @(posedge clk); #1;
    check({tag, "_done_idle"}, done, 0);
    check({tag, "_valid_idle"}, out_if.out_valid, 0);
    check({tag, "_clr_idle"}, acc_clear, 0);
    check({tag, "_ovr_idle"}, overrun, exp_overrun);
  endtask

  initial begin
    reset            = 1'b1;
    capture          = 1'b0;
    c_flat           = '0;
    out_if.out_ready = 1'b0;
    #1;
    check("rst_acc_clear", acc_clear, 0);
    check("rst_valid", out_if.out_valid, 0);
    check("rst_last", out_if.out_last, 0);
    check("rst_idx", out_if.out_idx, 0);
    check("rst_data", out_if.out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_overrun", overrun, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    idle_cycle("post_rst", 1'b0);

    // Basic drain, then a capture on the done cycle with random data and random ready.
    fill_pattern();
    start_capture("basic");
    drain("basic", 0, -1, -1, -1, -1);
    fill_random();
    start_capture("b2b");
    drain("b2b", 2, -1, -1, -1, -1);
    idle_cycle("b2b", 1'b0);

    fill_pattern();
    start_capture("bp");
    drain("bp", 1, -1, -1, -1, -1);
    idle_cycle("bp", 1'b0);

    fill_pattern();
    start_capture("snap");
    drain("snap", 0, -1, -1, 3, -1);
    idle_cycle("snap", 1'b0);

    fill_pattern();
    start_capture("ovr");
    drain("ovr", 0, 5, NN-1, -1, -1);
    for (int i = 0; i < 3; i++) idle_cycle("ovr", 1'b1);

    // Reset in the middle of a tile: outputs clear asynchronously and no done follows.
    fill_pattern();
    start_capture("mid");
    drain("mid", 0, -1, -1, -1, 7);
    out_if.out_ready = 1'b0;
    reset = 1'b1;
    #1;
    check("mid_rst_valid", out_if.out_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_last", out_if.out_last, 0);
    check("mid_rst_idx", out_if.out_idx, 0);
    check("mid_rst_data", out_if.out_data, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_clr", acc_clear, 0);
    check("mid_rst_overrun", overrun, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) idle_cycle("mid_after", 1'b0);

    fill_const(16'hABCD);
    start_capture("abcd");
    drain("abcd", 0, -1, -1, -1, -1);
    idle_cycle("abcd", 1'b0);

    for (int t = 0; t < 4; t++) begin
      fill_random();
      start_capture($sformatf("rnd%0d", t));
      drain($sformatf("rnd%0d", t), 2, -1, -1, -1, -1);
      idle_cycle($sformatf("rnd%0d", t), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
